// File: rtl/factor_pkg.sv
// Shared types and sizing helpers for the factor enumerator.
package factor_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        FINISH
    } state_t;

    function automatic int count_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mult_check.sv
// Combinational mult/3 relation test: hit when c matches a*b.
// FACTOR_EXACT_PRODUCT_EN selects full-width comparison instead of the wrapping one.
module mult_check #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             hit
);

`ifdef FACTOR_EXACT_PRODUCT_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign hit  = (prod == {{WIDTH{1'b0}}, c});
`else
    // WIDTH-sized context: the product wraps exactly like the mult/3 checker.
    logic [WIDTH-1:0] prod;
    assign prod = a * b;
    assign hit  = (prod == c);
`endif

endmodule

// File: rtl/factor_enumerator.sv
// Exhaustive enumerator of (A, B) pairs with C == A*B, streamed over valid/ready.
// Hit semantics (wrapping or exact) are selected by FACTOR_EXACT_PRODUCT_EN inside mult_check.
module factor_enumerator
    import factor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              target,
    output logic                          busy,
    output logic                          sol_valid,
    input  logic                          sol_ready,
    output logic [WIDTH-1:0]              sol_a,
    output logic [WIDTH-1:0]              sol_b,
    output logic                          done,
    output logic [count_width(WIDTH)-1:0] count
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hit;
    logic             last;

    assign last = (a == '1) && (b == '1);

    mult_check #(.WIDTH(WIDTH)) u_check (
        .a   (a),
        .b   (b),
        .c   (tgt),
        .hit (hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tgt       <= '0;
            a         <= '0;
            b         <= '0;
            busy      <= 1'b0;
            sol_valid <= 1'b0;
            sol_a     <= '0;
            sol_b     <= '0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt   <= target;
                        count <= '0;
                        a     <= '0;
                        b     <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        sol_a     <= a;
                        sol_b     <= b;
                        sol_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (last) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        b <= b + WIDTH'(1);
                        if (b == '1) a <= a + WIDTH'(1);
                    end
                end
                EMIT: begin
                    // Counters still hold the emitted candidate, so 'last' is valid here.
                    if (sol_ready) begin
                        sol_valid <= 1'b0;
                        count     <= count + CW'(1);
                        if (last) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            b <= b + WIDTH'(1);
                            if (b == '1) a <= a + WIDTH'(1);
                            state <= SCAN;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
